// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths and reader FSM state encoding for the conv block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int DATA_WIDTH_MEM_Z = 16;
    localparam int ADDR_WIDTH_MEM_Z = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_result_reader_fifo2.sv
// ============================================================================
// Module   : fifo2
// Brief    : Two-entry FIFO with head-of-queue output and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo2 #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Callers only pop when non-empty and only push when a slot is reserved.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/conv_result_reader.sv
// ============================================================================
// Module   : conv_result_reader
// Brief    : Streams Z-memory convolution results out as a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_reader #(
    parameter int DATA_WIDTH_MEM_Z = conv_pkg::DATA_WIDTH_MEM_Z,
    parameter int ADDR_WIDTH_MEM_Z = conv_pkg::ADDR_WIDTH_MEM_Z
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [ADDR_WIDTH_MEM_Z-1:0] mem_size_Z,
    output logic [ADDR_WIDTH_MEM_Z-1:0] mem_addr_Z,
    output logic                        read_Z,
    input  logic [DATA_WIDTH_MEM_Z-1:0] mem_data_Z,
    output logic [DATA_WIDTH_MEM_Z-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    import conv_pkg::*;

    localparam int                        c_FIFO_W = DATA_WIDTH_MEM_Z + 1;
    localparam logic [ADDR_WIDTH_MEM_Z-1:0] c_ONE  = 1;

    reader_state_t               r_state;
    reader_state_t               w_next_state;
    logic [ADDR_WIDTH_MEM_Z-1:0] r_size;
    logic [ADDR_WIDTH_MEM_Z-1:0] r_rd_addr;
    logic                        r_inflight;
    logic                        r_inflight_last;

    logic [1:0]                  w_fifo_count;
    logic [c_FIFO_W-1:0]         w_fifo_head;
    logic                        w_valid;
    logic                        w_pop;
    logic                        w_read;
    logic                        w_last_rd;
    logic [2:0]                  w_occ;

    assign w_valid   = (w_fifo_count != 2'd0);
    assign w_pop     = w_valid & out_ready;
    assign w_last_rd = (r_rd_addr == (r_size - c_ONE));
    // Slots committed after this cycle: buffered + returning - leaving.
    assign w_occ     = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);

    always_comb begin
        w_next_state = r_state;
        w_read       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                if (r_size == '0) begin
                    w_next_state = DONE;
                end else begin
                    w_read = (w_occ < 3'd2);
                    if (w_read && w_last_rd) begin
                        w_next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the final beat transfers so done lands right after it.
                if (!r_inflight &&
                    ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop))) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_size          <= '0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_size    <= mem_size_Z;
                r_rd_addr <= '0;
            end else if (w_read) begin
                r_rd_addr <= r_rd_addr + c_ONE;
            end
            r_inflight      <= w_read;
            r_inflight_last <= w_read & w_last_rd;
        end
    end

    fifo2 #(
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, mem_data_Z}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    assign mem_addr_Z = r_rd_addr;
    assign read_Z     = w_read;
    assign out_valid  = w_valid;
    assign out_data   = w_valid ? w_fifo_head[DATA_WIDTH_MEM_Z-1:0] : '0;
    assign out_last   = w_valid & w_fifo_head[DATA_WIDTH_MEM_Z];
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_result_reader.sv
// ============================================================================
// Module   : tb_conv_result_reader
// Brief    : Scoreboard bench for conv_result_reader with a Z memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conv_result_reader;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] mem_size_Z = '0;
    logic [AW-1:0] mem_addr_Z;
    logic          read_Z;
    logic [DW-1:0] mem_data_Z = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;

    conv_result_reader #(
        .DATA_WIDTH_MEM_Z (DW),
        .ADDR_WIDTH_MEM_Z (AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .mem_size_Z (mem_size_Z),
        .mem_addr_Z (mem_addr_Z),
        .read_Z     (read_Z),
        .mem_data_Z (mem_data_Z),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] zmem [64];
    always @(posedge clk) begin
        if (read_Z) mem_data_Z <= zmem[mem_addr_Z];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    exp_t exp_q[$];
    logic [AW-1:0] addr_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int beats, reads, dones, first_beat_cyc, last_beat_cyc, done_cyc, t0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic prev_last;
    int rdy_mode = 0;
    logic rdy_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 0;
                continue;
            end
            if (read_Z) begin
                reads++;
                addr_q.push_back(mem_addr_Z);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (prev_stall)
                check("stall_hold", {14'd0, out_valid, out_last, out_data},
                      {14'd0, 1'b1, prev_last, prev_data});
            if (out_valid && out_ready) begin
                if (beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beats++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0d expected no beat", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.d));
                    check("beat_last", 32'(out_last), 32'(e.l));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 1) out_ready = ($urandom_range(0, 9) >= 3);
            else               out_ready = rdy_fixed;
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) dut.u_fifo.o_count <= 2'd2)
        else $error("FAIL fifo_occupancy: got %0d expected <= 2", dut.u_fifo.o_count);

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(exp_t'{d: DW'(i * 3), l: (i == n - 1)});
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        beats = 0; reads = 0; dones = 0; done_cyc = -1; first_beat_cyc = -1;
        addr_q.delete();
        mem_size_Z = AW'(n);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int k = 0;
        while (dones == 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        check(name, 32'(dones > 0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) zmem[i] = DW'(i * 3);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data), 0);
        check("rst_out_last",  32'(out_last), 0);
        check("rst_read_Z",    32'(read_Z), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_done",      32'(done), 0);
        check("rst_addr",      32'(mem_addr_Z), 0);
        rstn = 1'b1;

        // N=9 streaming at full rate
        rdy_fixed = 1'b1;
        push_exp(9);
        do_start(9);
        wait_done(40, "A_done_seen");
        check("A_first_beat_cyc", 32'(first_beat_cyc - t0), 3);
        check("A_last_beat_cyc",  32'(last_beat_cyc - t0), 11);
        check("A_done_cyc",       32'(done_cyc - t0), 12);
        check("A_beats",          32'(beats), 9);
        check("A_reads",          32'(reads), 9);
        check("A_sb_empty",       32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
        check("A_idle_busy", 32'(busy), 0);

        // Empty readout
        do_start(0);
        wait_done(10, "B_done_seen");
        check("B_done_cyc", 32'(done_cyc - t0), 2);
        check("B_reads",    32'(reads), 0);
        check("B_beats",    32'(beats), 0);

        // N=35 with random backpressure
        rdy_mode = 1;
        push_exp(35);
        do_start(35);
        wait_done(500, "C_done_seen");
        rdy_mode = 0;
        check("C_beats",    32'(beats), 35);
        check("C_sb_empty", 32'(exp_q.size()), 0);

        // Consumer stalled for 10 cycles after start
        rdy_fixed = 1'b0;
        push_exp(5);
        do_start(5);
        repeat (9) @(posedge clk);
        #1;
        check("D_reads_stalled", 32'(reads), 2);
        check("D_read_Z_low",    32'(read_Z), 0);
        check("D_beats_stalled", 32'(beats), 0);
        check("D_valid_held",    32'(out_valid), 1);
        rdy_fixed = 1'b1;
        wait_done(40, "D_done_seen");
        check("D_beats",    32'(beats), 5);
        check("D_reads",    32'(reads), 5);
        check("D_sb_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset during a readout
        push_exp(20);
        do_start(20);
        for (int k = 0; k < 40 && beats < 4; k++) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("E_beats_before_rst", 32'(beats), 4);
        check("E_rst_valid", 32'(out_valid), 0);
        check("E_rst_data",  32'(out_data), 0);
        check("E_rst_last",  32'(out_last), 0);
        check("E_rst_busy",  32'(busy), 0);
        check("E_rst_read",  32'(read_Z), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("E_no_done", 32'(dones), 0);
        push_exp(3);
        do_start(3);
        wait_done(20, "E2_done_seen");
        check("E2_beats",    32'(beats), 3);
        check("E2_done_cyc", 32'(done_cyc - t0), 6);
        check("E2_sb_empty", 32'(exp_q.size()), 0);
        check("E2_naddr",    32'(addr_q.size()), 3);
        for (int i = 0; i < 3 && i < addr_q.size(); i++)
            check("E2_addr", 32'(addr_q[i]), 32'(i));

        // Second start while busy is ignored
        push_exp(6);
        do_start(6);
        repeat (2) @(posedge clk);
        #1;
        mem_size_Z = AW'(20);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, "F_done_seen");
        repeat (10) @(posedge clk);
        #1;
        check("F_beats",    32'(beats), 6);
        check("F_reads",    32'(reads), 6);
        check("F_dones",    32'(dones), 1);
        check("F_sb_empty", 32'(exp_q.size()), 0);
        check("F_idle",     32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
